surf_ps_sequencer: RTL and testbench
====================================

Name: surf_ps_sequencer

Overview:
Parametrised phase-shift sequencer for the SURF clock-infrastructure DCM. Software writes a signed target phase. The block then issues single-step PSEN/PSINCDEC requests, one at a time, until the DCM phase reaches the target. It handshakes on PSDONE, tracks the absolute position, enforces a soft range limit, and detects DCM PSLIMIT and missing-PSDONE timeouts. It replaces raw ps_en/ps_incdec pass-through from the register block and runs in the DCM PSCLK (33 MHz) domain.

Parameters:
POS_WIDTH, 10, width of signed position/target (two's complement).
MAX_POS, 255, soft limit; target is clamped to [-MAX_POS, +MAX_POS]. Must be < 2^(POS_WIDTH-1).
TIMEOUT_CYCLES, 255, clk_i cycles to wait for psdone_i before declaring a timeout.

Ports:
clk_i  in  1  PSCLK domain clock (33 MHz); the only clock.
rst_i  in  1  synchronous active-high reset.
target_i  in  POS_WIDTH  signed target phase; sampled only on an accepted go_i.
go_i  in  1  start request, single-cycle; accepted only in IDLE.
abort_i  in  1  stop after any step already in flight.
ps_en_o  out  1  DCM PSEN; one-cycle pulse per step.
ps_incdec_o  out  1  DCM PSINCDEC; 1 = increment; held stable from STEP through WAIT.
psdone_i  in  1  DCM PSDONE.
pslimit_i  in  1  DCM STATUS[0] (phase-shift overflow).
busy_o  out  1  high in any state other than IDLE.
done_o  out  1  one-cycle pulse when a sequence ends (success, abort or error).
err_limit_o  out  1  sticky; DCM limit hit; cleared on next accepted go_i.
err_timeout_o  out  1  sticky; psdone_i missing; cleared on next accepted go_i.
position_o  out  POS_WIDTH  signed current phase position in steps.

Behaviour:
- Reset, taking effect at the next clk_i edge:
  - state = IDLE.
  - All outputs 0, including position_o = 0.
  - Timeout counter = 0.
  - The integrator must reset the DCM together with this block.
  - Reset mid-sequence abandons the sequence; no done_o is produced.
- States: IDLE, CMP, STEP, WAIT, FIN.
- IDLE:
  - go_i = 1 → latch clamp(target_i) into an internal target register.
  - Clear both error flags, go to CMP.
  - go_i in any other state is ignored.
  - psdone_i in IDLE is ignored.
- CMP:
  - target == position, or abort flag set → FIN.
  - Otherwise register dir = (target > position), signed compare, and go to STEP.
- STEP (1 cycle):
  - ps_en_o = 1 and ps_incdec_o = dir.
  - Clear the timeout counter, go to WAIT.
  - An abort in STEP is latched; the step still completes.
- WAIT:
  - ps_en_o = 0; the counter increments each cycle.
  - psdone_i = 1 with pslimit_i = 1 in the same cycle: position unchanged, err_limit_o = 1, go to FIN.
  - psdone_i = 1 with pslimit_i = 0: position ±1 per dir, go to CMP.
  - Counter reaches TIMEOUT_CYCLES with no psdone_i: err_timeout_o = 1, position unchanged, go to FIN.
  - psdone_i on the same cycle the counter hits TIMEOUT_CYCLES: psdone_i wins.
- abort_i:
  - Sampled in any busy state into an abort flag; the flag is cleared in FIN.
  - In WAIT the in-flight step is finished first (PSEN cannot be retracted).
- FIN (1 cycle): done_o = 1, go to IDLE.
- Latency:
  - go accepted at edge N → CMP at N+1 → STEP at N+2, so ps_en_o is high during cycle N+2.
  - Each step costs 3 cycles plus the DCM psdone latency.
  - A zero-distance go raises done_o during cycle N+2.
- Clamping: target_i > MAX_POS becomes MAX_POS; target_i < -MAX_POS becomes -MAX_POS. Position therefore never wraps.
- Outputs are registered; there is no combinational path from input to output.

Test Plan:
1. Reset, then go_i with target_i = +5 and a DCM model giving psdone 4 cycles after PSEN → 5 ps_en_o pulses with ps_incdec_o = 1; position_o = 5; one done_o; no errors; busy_o low afterwards.
2. From position 5, go_i with target_i = -3 → 8 pulses with ps_incdec_o = 0; position_o = -3 (10'h3FD); done_o once.
3. target_i = +400 with MAX_POS = 255 → position_o ends at 255 after 255 steps.
4. Model asserts pslimit_i together with the 3rd psdone → err_limit_o = 1, position_o = 2, done_o pulse. The next go_i clears err_limit_o.
5. Model never returns psdone → done_o and err_timeout_o arrive exactly TIMEOUT_CYCLES cycles after the ps_en_o pulse; position_o unchanged.
6. abort_i during WAIT of step 2 toward +10 → step 2 completes, position_o = 2, done_o, no error. Separately, rst_i asserted mid-WAIT → all outputs 0 on the next edge and no done_o.

Source files
------------

// File: rtl/surf_ps_sequencer.sv
// Phase-shift sequencer for the SURF DCM. It walks PSEN/PSINCDEC one step at a time
// toward a clamped signed target, with PSDONE handshake, limit and timeout detection.
module surf_ps_sequencer #(
  parameter int POS_WIDTH      = 10,
  parameter int MAX_POS        = 255,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic signed [POS_WIDTH-1:0] target_i,
  input  logic                        go_i,
  input  logic                        abort_i,
  output logic                        ps_en_o,
  output logic                        ps_incdec_o,
  input  logic                        psdone_i,
  input  logic                        pslimit_i,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        err_limit_o,
  output logic                        err_timeout_o,
  output logic signed [POS_WIDTH-1:0] position_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic signed [POS_WIDTH-1:0] MAX_S   = POS_WIDTH'(MAX_POS);
  localparam logic signed [POS_WIDTH-1:0] MIN_S   = -MAX_S;
  localparam logic signed [POS_WIDTH-1:0] POS_ONE = POS_WIDTH'(1);
  // The PSEN cycle is the first cycle of the timeout window, so the last WAIT
  // cycle carries count TIMEOUT_CYCLES-2 (requires TIMEOUT_CYCLES >= 2).
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 2);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CMP  = 3'd1,
    S_STEP = 3'd2,
    S_WAIT = 3'd3,
    S_FIN  = 3'd4
  } state_t;

  function automatic logic signed [POS_WIDTH-1:0] clamp_target(
    input logic signed [POS_WIDTH-1:0] t
  );
    logic signed [POS_WIDTH-1:0] r;
    if (t > MAX_S) begin
      r = MAX_S;
    end else if (t < MIN_S) begin
      r = MIN_S;
    end else begin
      r = t;
    end
    return r;
  endfunction

  state_t                      state_q;
  logic signed [POS_WIDTH-1:0] tgt_q;
  logic signed [POS_WIDTH-1:0] pos_q;
  logic signed [POS_WIDTH-1:0] tgt_d;
  logic [CNT_W-1:0]            cnt_q;
  logic                        abort_q;
  logic                        ps_en_q;
  logic                        ps_incdec_q;
  logic                        busy_q;
  logic                        done_q;
  logic                        err_limit_q;
  logic                        err_timeout_q;

  assign tgt_d = clamp_target(target_i);

  // Sequencer FSM; every output is a register updated alongside the state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= S_IDLE;
      tgt_q         <= '0;
      pos_q         <= '0;
      cnt_q         <= '0;
      abort_q       <= 1'b0;
      ps_en_q       <= 1'b0;
      ps_incdec_q   <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_limit_q   <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      ps_en_q <= 1'b0;
      done_q  <= 1'b0;
      if (abort_i && (state_q != S_IDLE)) begin
        abort_q <= 1'b1;
      end
      case (state_q)
        S_IDLE: begin
          if (go_i) begin
            tgt_q         <= tgt_d;
            err_limit_q   <= 1'b0;
            err_timeout_q <= 1'b0;
            busy_q        <= 1'b1;
            state_q       <= S_CMP;
          end
        end
        S_CMP: begin
          if ((tgt_q == pos_q) || abort_q) begin
            done_q  <= 1'b1;
            state_q <= S_FIN;
          end else begin
            ps_incdec_q <= (tgt_q > pos_q);
            ps_en_q     <= 1'b1;
            state_q     <= S_STEP;
          end
        end
        S_STEP: begin
          cnt_q   <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          cnt_q <= cnt_q + CNT_ONE;
          // PSDONE takes priority over a timeout landing on the same cycle.
          if (psdone_i) begin
            if (pslimit_i) begin
              err_limit_q <= 1'b1;
              done_q      <= 1'b1;
              state_q     <= S_FIN;
            end else begin
              pos_q   <= ps_incdec_q ? (pos_q + POS_ONE) : (pos_q - POS_ONE);
              state_q <= S_CMP;
            end
          end else if (cnt_q == CNT_LAST) begin
            err_timeout_q <= 1'b1;
            done_q        <= 1'b1;
            state_q       <= S_FIN;
          end
        end
        S_FIN: begin
          abort_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign ps_en_o       = ps_en_q;
  assign ps_incdec_o   = ps_incdec_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign err_limit_o   = err_limit_q;
  assign err_timeout_o = err_timeout_q;
  assign position_o    = pos_q;

endmodule

// File: tb/tb_surf_ps_sequencer.sv
// Bench for surf_ps_sequencer: a behavioural DCM model plus a table of directed
// sequences and hand-written corner cases (latency, timeout timing, reset mid-step).
module tb_surf_ps_sequencer;

  logic              clk = 1'b0;
  logic              rst_i = 1'b0;
  logic signed [9:0] target_i = 10'sd0;
  logic              go_i = 1'b0;
  logic              abort_i = 1'b0;
  logic              ps_en_o;
  logic              ps_incdec_o;
  logic              psdone_i = 1'b0;
  logic              pslimit_i = 1'b0;
  logic              busy_o;
  logic              done_o;
  logic              err_limit_o;
  logic              err_timeout_o;
  logic signed [9:0] position_o;

  surf_ps_sequencer #(.POS_WIDTH(10), .MAX_POS(255), .TIMEOUT_CYCLES(255)) dut (
    .clk_i(clk), .rst_i(rst_i), .target_i(target_i), .go_i(go_i), .abort_i(abort_i),
    .ps_en_o(ps_en_o), .ps_incdec_o(ps_incdec_o), .psdone_i(psdone_i),
    .pslimit_i(pslimit_i), .busy_o(busy_o), .done_o(done_o),
    .err_limit_o(err_limit_o), .err_timeout_o(err_timeout_o), .position_o(position_o)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // DCM model state: counters only grow; the stimulus side works with deltas.
  int cyc = 0, cd = 0;
  int en_total = 0, inc_total = 0, dec_total = 0, done_total = 0, psdone_total = 0;
  int limit_abs = -1;
  int model_delay = 4;
  bit model_mute = 1'b0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    psdone_i = 1'b0;
    pslimit_i = 1'b0;
    if (rst_i) begin
      cd = 0;
    end else if (cd > 0) begin
      cd = cd - 1;
      if (cd == 0) begin
        psdone_total = psdone_total + 1;
        psdone_i = 1'b1;
        pslimit_i = (psdone_total == limit_abs);
      end
    end
    if (ps_en_o) begin
      en_total = en_total + 1;
      if (ps_incdec_o) inc_total = inc_total + 1;
      else dec_total = dec_total + 1;
      if (!model_mute && !rst_i) cd = model_delay;
    end
    if (done_o) done_total = done_total + 1;
  end

  typedef struct {
    bit pre_reset;
    int target;
    int delay;
    int limit_at;
    bit mute;
    int abort_at;
    int exp_pos;
    int exp_inc;
    int exp_dec;
    bit exp_elim;
    bit exp_eto;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input int act, input int exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick();
    go_i = 1'b0;
    abort_i = 1'b0;
    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
    tick();
  endtask

  task automatic pulse_go(input int tgt);
    tick();
    target_i = tgt[9:0];
    go_i = 1'b1;
    tick();
    go_i = 1'b0;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int en0, inc0, dec0, done0;
    bit got, aborted;
    if (v.pre_reset) do_reset();
    model_delay = v.delay;
    model_mute = v.mute;
    limit_abs = (v.limit_at != 0) ? (psdone_total + v.limit_at) : -1;
    en0 = en_total; inc0 = inc_total; dec0 = dec_total; done0 = done_total;
    pulse_go(v.target);
    got = 1'b0;
    aborted = 1'b0;
    for (int c = 0; c < 4000 && !got; c++) begin
      tick();
      if (v.abort_at != 0 && !aborted && (en_total - en0) == v.abort_at && !ps_en_o) begin
        abort_i = 1'b1;
        aborted = 1'b1;
      end else begin
        abort_i = 1'b0;
      end
      if (done_total != done0) got = 1'b1;
    end
    abort_i = 1'b0;
    if (!got) check($sformatf("v%0d_done_wait", idx), 0, 1);
    repeat (3) tick();
    check($sformatf("v%0d_position", idx), int'(position_o), v.exp_pos);
    check($sformatf("v%0d_inc_pulses", idx), inc_total - inc0, v.exp_inc);
    check($sformatf("v%0d_dec_pulses", idx), dec_total - dec0, v.exp_dec);
    check($sformatf("v%0d_done_count", idx), done_total - done0, 1);
    check($sformatf("v%0d_err_limit", idx), int'(err_limit_o), int'(v.exp_elim));
    check($sformatf("v%0d_err_timeout", idx), int'(err_timeout_o), int'(v.exp_eto));
    check($sformatf("v%0d_busy_after", idx), int'(busy_o), 0);
  endtask

  initial begin
    int c0, c1, en0, done0;
    bit got;
    //            rst   tgt  dly lim mute  abrt  pos  inc  dec  elim  eto
    vecs[0]  = '{1'b1,    5, 4, 0, 1'b0, 0,    5,   5,   0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0,   -3, 4, 0, 1'b0, 0,   -3,   0,   8, 1'b0, 1'b0};
    vecs[2]  = '{1'b1,  400, 4, 0, 1'b0, 0,  255, 255,   0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1,   10, 4, 3, 1'b0, 0,    2,   3,   0, 1'b1, 1'b0};
    vecs[4]  = '{1'b0,    0, 4, 0, 1'b0, 0,    0,   0,   2, 1'b0, 1'b0};
    vecs[5]  = '{1'b0,    7, 4, 0, 1'b1, 0,    0,   1,   0, 1'b0, 1'b1};
    vecs[6]  = '{1'b1,   10, 4, 0, 1'b0, 2,    2,   2,   0, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, -400, 4, 0, 1'b0, 0, -255,   0, 257, 1'b0, 1'b0};
    vecs[8]  = '{1'b0,    3, 1, 0, 1'b0, 0,    3, 258,   0, 1'b0, 1'b0};
    vecs[9]  = '{1'b0,    3, 4, 0, 1'b0, 0,    3,   0,   0, 1'b0, 1'b0};
    vecs[10] = '{1'b1,   -1, 6, 1, 1'b0, 0,    0,   0,   1, 1'b1, 1'b0};

    // Reset state
    do_reset();
    check("reset_outputs",
          int'({ps_en_o, ps_incdec_o, busy_o, done_o, err_limit_o, err_timeout_o}), 0);
    check("reset_position", int'(position_o), 0);

    // Zero-distance go: CMP cycle, then done in the following cycle
    pulse_go(0);
    check("zd_cmp_done_low", int'(done_o), 0);
    check("zd_cmp_busy", int'(busy_o), 1);
    tick();
    check("zd_done_latency", int'(done_o), 1);
    check("zd_no_step", int'(ps_en_o), 0);
    tick();
    check("zd_done_single", int'(done_o), 0);
    check("zd_idle_busy", int'(busy_o), 0);

    // First-step latency: PSEN one cycle after CMP
    model_delay = 4;
    model_mute = 1'b0;
    limit_abs = -1;
    done0 = done_total;
    pulse_go(1);
    check("step_cmp_no_en", int'(ps_en_o), 0);
    tick();
    check("step_latency_en", int'(ps_en_o), 1);
    check("step_incdec", int'(ps_incdec_o), 1);
    got = 1'b0;
    for (int c = 0; c < 40 && !got; c++) begin
      tick();
      if (done_total != done0) got = 1'b1;
    end
    check("step_done_seen", int'(got), 1);
    check("step_position", int'(position_o), 1);

    // Timeout timing with a mute DCM; a go while busy must be ignored
    model_mute = 1'b1;
    en0 = en_total;
    pulse_go(7);
    got = 1'b0;
    c0 = 0;
    for (int c = 0; c < 10 && !got; c++) begin
      tick();
      if (ps_en_o) begin got = 1'b1; c0 = cyc; end
    end
    check("to_en_seen", int'(got), 1);
    target_i = -10'sd50;
    go_i = 1'b1;
    tick();
    go_i = 1'b0;
    got = 1'b0;
    c1 = 0;
    for (int c = 0; c < 400 && !got; c++) begin
      if (done_o) begin got = 1'b1; c1 = cyc; end
      else tick();
    end
    check("to_done_seen", int'(got), 1);
    check("to_latency", c1 - c0, 255);
    check("to_err_timeout", int'(err_timeout_o), 1);
    check("to_err_limit", int'(err_limit_o), 0);
    check("to_position", int'(position_o), 1);
    repeat (3) tick();
    check("to_busy_go_ignored", int'(busy_o), 0);
    check("to_single_step", en_total - en0, 1);
    model_mute = 1'b0;

    // Reset during WAIT of the second step: outputs cleared, no done afterwards
    en0 = en_total;
    pulse_go(5);
    got = 1'b0;
    for (int c = 0; c < 40 && !got; c++) begin
      tick();
      if ((en_total - en0) == 2) got = 1'b1;
    end
    check("rst_second_step_seen", int'(got), 1);
    check("rst_pos_before", int'(position_o), 2);
    tick();
    rst_i = 1'b1;
    tick();
    check("rst_mid_outputs",
          int'({ps_en_o, ps_incdec_o, busy_o, done_o, err_limit_o, err_timeout_o}), 0);
    check("rst_mid_position", int'(position_o), 0);
    rst_i = 1'b0;
    done0 = done_total;
    en0 = en_total;
    repeat (20) tick();
    check("rst_no_done", done_total - done0, 0);
    check("rst_no_step", en_total - en0, 0);

    // Table-driven sequences (state carries over unless pre_reset)
    for (int i = 0; i < 11; i++) run_vec(i, vecs[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
